// File: rtl/alu4_nibble_seq_if.sv
// Request/response bus of the nibble-serial ALU sequencer.
// The master side issues word-wide ALU requests and consumes results;
// the slave side is the sequencer itself.
interface alu4_nibble_seq_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    // Request channel
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_m;
    logic         req_ai;
    logic         req_bi;
    logic         req_cin;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;

    // Response channel
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_out;
    logic         resp_cout;
    logic         resp_zero;

    modport master (
        output req_valid, req_m, req_ai, req_bi, req_cin, req_a, req_b,
        input  req_ready,
        input  resp_valid, resp_out, resp_cout, resp_zero,
        output resp_ready
    );

    modport slave (
        input  req_valid, req_m, req_ai, req_bi, req_cin, req_a, req_b,
        output req_ready,
        output resp_valid, resp_out, resp_cout, resp_zero,
        input  resp_ready
    );
endinterface

// File: rtl/alu4_nibble_seq.sv
// Nibble-serial sequencer for a single 4-bit ALU slice.
// A word-wide request is fed to the slice one nibble per clock, LSB first,
// with the slice carry registered between nibbles; the result is assembled
// in a shift register and presented on the response channel.
module alu4_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu4_nibble_seq_if.slave    bus,
    output logic [1:0]          alu_m,
    output logic                alu_ai,
    output logic                alu_bi,
    output logic                alu_kin,
    output logic [3:0]          alu_a,
    output logic [3:0]          alu_b,
    input  logic [3:0]          alu_out,
    input  logic                alu_kout
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             carry_q,     carry_d;
    logic [W-1:0]     a_sh_q,      a_sh_d;
    logic [W-1:0]     b_sh_q,      b_sh_d;
    logic [W-1:0]     res_sh_q,    res_sh_d;
    logic [1:0]       cfg_m_q,     cfg_m_d;
    logic             cfg_ai_q,    cfg_ai_d;
    logic             cfg_bi_q,    cfg_bi_d;
    logic [W-1:0]     resp_out_q,  resp_out_d;
    logic             resp_cout_q, resp_cout_d;
    logic             resp_zero_q, resp_zero_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [W-1:0]     final_s;

    // Next-state, datapath and output-flag computation for the sequencer.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_sh_d     = res_sh_q;
        cfg_m_d      = cfg_m_q;
        cfg_ai_d     = cfg_ai_q;
        cfg_bi_d     = cfg_bi_q;
        resp_out_d   = resp_out_q;
        resp_cout_d  = resp_cout_q;
        resp_zero_d  = resp_zero_q;
        // Result as it will stand once the current slice nibble is shifted in.
        final_s      = {alu_out, res_sh_q[W-1:4]};

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    cfg_m_d  = bus.req_m;
                    cfg_ai_d = bus.req_ai;
                    cfg_bi_d = bus.req_bi;
                    a_sh_d   = bus.req_a;
                    b_sh_d   = bus.req_b;
                    carry_d  = bus.req_cin;
                    idx_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                carry_d  = alu_kout;
                a_sh_d   = {4'd0, a_sh_q[W-1:4]};
                b_sh_d   = {4'd0, b_sh_q[W-1:4]};
                res_sh_d = final_s;
                if (idx_q == IDX_LAST) begin
                    idx_d       = '0;
                    resp_out_d  = final_s;
                    resp_cout_d = alu_kout;
                    resp_zero_d = (final_s == '0);
                    state_d     = ST_DONE;
                end else begin
                    idx_d       = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next-state decode.
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_DONE);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_sh_q     <= '0;
            cfg_m_q      <= 2'd0;
            cfg_ai_q     <= 1'b0;
            cfg_bi_q     <= 1'b0;
            resp_out_q   <= '0;
            resp_cout_q  <= 1'b0;
            resp_zero_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_sh_q     <= res_sh_d;
            cfg_m_q      <= cfg_m_d;
            cfg_ai_q     <= cfg_ai_d;
            cfg_bi_q     <= cfg_bi_d;
            resp_out_q   <= resp_out_d;
            resp_cout_q  <= resp_cout_d;
            resp_zero_q  <= resp_zero_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Slice drive: active only in RUN so the slice is quiescent otherwise.
    always_comb begin
        if (state_q == ST_RUN) begin
            alu_a   = a_sh_q[3:0];
            alu_b   = b_sh_q[3:0];
            alu_kin = carry_q;
            alu_m   = cfg_m_q;
            alu_ai  = cfg_ai_q;
            alu_bi  = cfg_bi_q;
        end else begin
            alu_a   = 4'd0;
            alu_b   = 4'd0;
            alu_kin = 1'b0;
            alu_m   = 2'd0;
            alu_ai  = 1'b0;
            alu_bi  = 1'b0;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_out   = resp_out_q;
    assign bus.resp_cout  = resp_cout_q;
    assign bus.resp_zero  = resp_zero_q;
endmodule

// File: tb/tb_alu4_nibble_seq.sv
// Bench for alu4_nibble_seq: a stub slice, a word-level reference model
// checked every cycle, and directed vectors with hand-computed results.
module tb_alu4_nibble_seq;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   alu_m;
    logic         alu_ai, alu_bi, alu_kin, alu_kout;
    logic [3:0]   alu_a, alu_b, alu_out;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    alu4_nibble_seq_if #(.NIBBLES(NIB)) bus ();

    alu4_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_m    (alu_m),
        .alu_ai   (alu_ai),
        .alu_bi   (alu_bi),
        .alu_kin  (alu_kin),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .alu_kout (alu_kout)
    );

    // Stub slice: M=00 adds A+B+Kin; other modes XOR the (optionally inverted)
    // operands and report bit 3 of the result as Kout.
    always_comb begin
        alu_out  = 4'd0;
        alu_kout = 1'b0;
        if (alu_m == 2'b00) begin
            {alu_kout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_kin};
        end else begin
            alu_out  = (alu_ai ? ~alu_a : alu_a) ^ (alu_bi ? ~alu_b : alu_b);
            alu_kout = alu_out[3];
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- word-level reference model ----------------
    // Whole-word result of the slice function: {cout, result}.
    function automatic logic [W:0] word_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic [1:0] m,
                                           input logic ai, input logic bi);
        logic [W-1:0] r;
        if (m == 2'b00) begin
            return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
        r = (ai ? ~a : a) ^ (bi ? ~b : b);
        return {r[W-1], r};
    endfunction

    int           m_st = 0;     // 0 idle, 1 run, 2 done
    int           m_k  = 0;
    int           cyc  = 0;
    logic [W-1:0] m_a, m_b, m_res;
    logic         m_cin, m_ai, m_bi, m_cout;
    logic [1:0]   m_m;
    logic [W-1:0] m_rout;
    logic         m_rcout, m_rzero;
    logic [W:0]   nx;
    int           acc_cyc[$];
    logic         chk_en = 1'b0;
    logic         kin_log [NIB];

    assign nx = word_op(bus.req_a, bus.req_b, bus.req_cin, bus.req_m, bus.req_ai, bus.req_bi);

    // Carry expected into nibble k: carry out of the low 4k bits of the word op.
    function automatic logic exp_kin(input int k);
        logic [63:0] mask, s;
        if (k == 0) return m_cin;
        if (m_m != 2'b00) return m_res[4*k-1];
        mask = (64'd1 << (4*k)) - 64'd1;
        s = (64'(m_a) & mask) + (64'(m_b) & mask) + 64'(m_cin);
        return s[4*k];
    endfunction

    // Model transaction progress on each rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_st    <= 0;
            m_k     <= 0;
            m_rout  <= '0;
            m_rcout <= 1'b0;
            m_rzero <= 1'b0;
        end else begin
            case (m_st)
                0: if (bus.req_valid) begin
                    m_a <= bus.req_a;  m_b <= bus.req_b;  m_cin <= bus.req_cin;
                    m_m <= bus.req_m;  m_ai <= bus.req_ai; m_bi <= bus.req_bi;
                    m_res <= nx[W-1:0]; m_cout <= nx[W];
                    m_st <= 1; m_k <= 0;
                    acc_cyc.push_back(cyc);
                end
                1: if (m_k == NIB-1) begin
                    m_st <= 2; m_rout <= m_res; m_rcout <= m_cout; m_rzero <= (m_res == '0);
                end else begin
                    m_k <= m_k + 1;
                end
                2: if (bus.resp_ready) m_st <= 0;
                default: m_st <= 0;
            endcase
        end
    end

    // Every-cycle comparison of DUT outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready",  W'(bus.req_ready),  W'(m_st == 0));
            check("resp_valid", W'(bus.resp_valid), W'(m_st == 2));
            check("resp_out",   bus.resp_out,       m_rout);
            check("resp_cout",  W'(bus.resp_cout),  W'(m_rcout));
            check("resp_zero",  W'(bus.resp_zero),  W'(m_rzero));
            if (m_st == 1) begin
                check("alu_a",   W'(alu_a),   W'(m_a[4*m_k +: 4]));
                check("alu_b",   W'(alu_b),   W'(m_b[4*m_k +: 4]));
                check("alu_kin", W'(alu_kin), W'(exp_kin(m_k)));
                check("alu_m",   W'(alu_m),   W'(m_m));
                check("alu_ai",  W'(alu_ai),  W'(m_ai));
                check("alu_bi",  W'(alu_bi),  W'(m_bi));
                kin_log[m_k] <= alu_kin;
            end else begin
                check("alu_idle", W'({alu_a, alu_b, alu_kin, alu_m, alu_ai, alu_bi}), W'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [1:0] m, input logic ai, input logic bi);
        bus.req_a = a; bus.req_b = b; bus.req_cin = cin;
        bus.req_m = m; bus.req_ai = ai; bus.req_bi = bi;
    endtask

    // Issue one request and count edges after acceptance until resp_valid.
    task automatic send_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                             input logic [1:0] m, input logic ai, input logic bi, output int lat);
        drive(a, b, cin, m, ai, bi);
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        if (lat >= 20) check("resp_timeout", W'(0), W'(1));
    endtask

    task automatic ack();
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    int lat;

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        drive('0, '0, 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_req_ready",  W'(bus.req_ready),  W'(1));
        check("rst_resp_valid", W'(bus.resp_valid), W'(0));
        check("rst_resp_out",   bus.resp_out,       W'(0));

        // Carry ripple across nibbles, with latency and Kin sequence
        send_wait(16'h0FFF, 16'h0001, 1'b0, 2'b00, 1'b0, 1'b0, lat);
        check("latency",     W'(lat),            W'(4));
        check("ripple_out",  bus.resp_out,       16'h1000);
        check("ripple_cout", W'(bus.resp_cout),  W'(0));
        check("ripple_zero", W'(bus.resp_zero),  W'(0));
        check("ripple_kin",  W'({kin_log[3], kin_log[2], kin_log[1], kin_log[0]}), W'(4'b1110));
        ack();

        // Wrap to zero
        send_wait(16'hFFFF, 16'h0001, 1'b0, 2'b00, 1'b0, 1'b0, lat);
        check("wrap_out",  bus.resp_out,      16'h0000);
        check("wrap_cout", W'(bus.resp_cout), W'(1));
        check("wrap_zero", W'(bus.resp_zero), W'(1));
        ack();

        // Carry in on nibble 0
        send_wait(16'h1234, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, lat);
        check("cin_out",  bus.resp_out,      16'h1235);
        check("cin_cout", W'(bus.resp_cout), W'(0));
        ack();

        // Mode/control pass-through: ~A ^ B
        send_wait(16'h1234, 16'h00FF, 1'b0, 2'b10, 1'b1, 1'b0, lat);
        check("logic_out",  bus.resp_out,      16'hED34);
        check("logic_cout", W'(bus.resp_cout), W'(1));
        check("logic_zero", W'(bus.resp_zero), W'(0));
        ack();

        // Back-pressure in DONE
        send_wait(16'h00AA, 16'h0055, 1'b0, 2'b00, 1'b0, 1'b0, lat);
        repeat (3) step();
        check("bp_valid", W'(bus.resp_valid), W'(1));
        check("bp_ready", W'(bus.req_ready),  W'(0));
        check("bp_out",   bus.resp_out,       16'h00FF);
        ack();
        check("bp_release", W'(bus.req_ready), W'(1));

        // Request pulsed while busy is ignored
        drive(16'h1111, 16'h2222, 1'b0, 2'b00, 1'b0, 1'b0);
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        drive(16'hFFFF, 16'hFFFF, 1'b1, 2'b10, 1'b1, 1'b1);
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("busy_out", bus.resp_out, 16'h3333);
        ack();
        repeat (8) step();
        check("busy_no_extra", W'(bus.resp_valid), W'(0));

        // Reset in the second RUN cycle
        drive(16'h0F0F, 16'h0101, 1'b0, 2'b00, 1'b0, 1'b0);
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_ready", W'(bus.req_ready),  W'(1));
        check("mid_rst_valid", W'(bus.resp_valid), W'(0));
        check("mid_rst_out",   bus.resp_out,       W'(0));
        check("mid_rst_flags", W'({bus.resp_cout, bus.resp_zero}), W'(0));
        check("mid_rst_alu",   W'({alu_a, alu_b, alu_kin}), W'(0));
        send_wait(16'h0F0F, 16'h0101, 1'b0, 2'b00, 1'b0, 1'b0, lat);
        check("post_rst_out", bus.resp_out, 16'h1010);
        ack();

        // Continuously held request: accept period
        acc_cyc.delete();
        drive(16'h0001, 16'h0002, 1'b0, 2'b00, 1'b0, 1'b0);
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        repeat (14) step();
        bus.req_valid = 1'b0;
        repeat (8) step();
        bus.resp_ready = 1'b0;
        check("acc_count", W'(acc_cyc.size() >= 3), W'(1));
        if (acc_cyc.size() >= 3) begin
            check("period_1", W'(acc_cyc[1] - acc_cyc[0]), W'(6));
            check("period_2", W'(acc_cyc[2] - acc_cyc[1]), W'(6));
        end
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
